montprod_opmem: RTL and testbench
=================================

Name: montprod_opmem

Overview:
- Operand and result store plus launch sequencer for montprod.
- Host loads A, B and M words through a simple word-addressed port, then starts the operation.
- Block serves montprod's opa/opb/opm read ports with registered 1-cycle reads, and captures result_we writes into the R bank.
- Block pulses calculate, waits for ready, then flags done; host reads R back through the same port.

Parameters:
- MEM_WORDS, 256, words per bank (address width 8).
- DATA_WIDTH, 32, word width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- host_cs  in  1  host access strobe
- host_we  in  1  host write (1) / read (0)
- host_addr  in  10  [9:8] bank select (0=A, 1=B, 2=M, 3=R); [7:0] word index
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data, registered
- start  in  1  launch request, single-cycle pulse
- length  in  8  operand length in words, sampled on start
- busy  out  1  operation in progress
- done  out  1  sticky completion flag; cleared by start
- error  out  1  sticky; set on start with length==0; cleared by next start
- mp_calculate  out  1  calculate pulse to montprod
- mp_length  out  8  latched length to montprod
- mp_ready  in  1  montprod ready
- opa_addr / opb_addr / opm_addr  in  8 each  montprod read addresses
- opa_data / opb_data / opm_data  out  32 each  registered read data
- result_addr  in  8  montprod result address
- result_data  in  32  montprod result data
- result_we  in  1  montprod result write enable

Behaviour:
- Reset (async) sets host_rdata=0, busy=0, done=0, error=0, mp_calculate=0, mp_length=0, opX_data=0, FSM=IDLE.
- Memory contents are not reset. A reset mid-operation aborts: FSM→IDLE, mp_calculate low, R bank keeps partial contents.
- Operand read ports: opX_data <= bank[opX_addr] every clock. Latency 1, free-running, independent of FSM.
- Result port: result_we=1 writes result_data to R[result_addr] on that clock edge, in any FSM state.
- Host read: host_cs=1, host_we=0 gives host_rdata = bank[addr] one cycle later. Otherwise host_rdata holds its value. All banks are readable at any time.
- Host write: host_cs=1, host_we=1 to A/B/M is accepted only when busy=0; it is ignored while busy. Host writes to bank R are always ignored.
- Same-cycle read and write of the same word (host write vs montprod read, or result write vs host read): the read returns old data (read-before-write).
- FSM states:
  - IDLE: start with length!=0 → latch mp_length, clear done/error, busy=1, go to LAUNCH. Start with length==0 → error=1, done=1, stay in IDLE.
  - LAUNCH: mp_calculate=1 for exactly one cycle → WAIT_LOW.
  - WAIT_LOW: wait for mp_ready=0 → WAIT_HIGH. This guards against a stale ready.
  - WAIT_HIGH: on mp_ready=1, busy=0, done=1, go to IDLE.
- start while busy=1 is ignored.
- start in the same cycle as a host write to A/B/M: the write is accepted, because busy is still 0 that cycle.

Optional Feature:
- Macro: MONTPROD_OPMEM_CLEAR_EN.
- Defined: IDLE→CLEAR instead of LAUNCH. CLEAR writes 0 to R[0..MEM_WORDS-1], one word per cycle (256 cycles), then → LAUNCH. Any result_we arriving during CLEAR takes priority for its address.
- Undefined: no CLEAR state. R keeps previous contents beyond the written range.

Test Plan:
- Reset with start/host idle → all outputs 0, FSM IDLE. Assert reset_n=0 mid-WAIT_HIGH → busy=0, mp_calculate=0 immediately.
- Host writes A[0]=0x9, B[0]=0x7, M[0]=0x13; start with length=1 and real montprod attached → mp_calculate one cycle, busy until ready returns, done=1, host read of R[0] returns 0x00000001.
- Host read latency: write A[5]=0xDEADBEEF, read addr 0x005 → host_rdata=0xDEADBEEF exactly one cycle after cs. Drive opa_addr=5 → opa_data=0xDEADBEEF the next cycle.
- While busy, write A[0]=0xFFFFFFFF and a second start → A[0] unchanged, no second mp_calculate. Host write to addr 0x300 → R[0] unchanged.
- start with length=0 → error=1, done=1, mp_calculate never asserted. Next start with length=1 clears both.
- With MONTPROD_OPMEM_CLEAR_EN: preload R[200]=0x1234 via result_we, start → after 256 CLEAR cycles mp_calculate pulses, and R[200] reads 0. Without the macro, R[200] still reads 0x1234.

Source files
------------

// File: rtl/montprod_opmem.sv
// montprod_opmem: A/B/M/R word banks, host port and launch sequencer for montprod; define MONTPROD_OPMEM_CLEAR_EN to zero R before each launch
module montprod_opmem #(
  parameter int MEM_WORDS  = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_cs,
  input  logic                  host_we,
  input  logic [9:0]            host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  start,
  input  logic [7:0]            length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  mp_calculate,
  output logic [7:0]            mp_length,
  input  logic                  mp_ready,
  input  logic [7:0]            opa_addr,
  input  logic [7:0]            opb_addr,
  input  logic [7:0]            opm_addr,
  output logic [DATA_WIDTH-1:0] opa_data,
  output logic [DATA_WIDTH-1:0] opb_data,
  output logic [DATA_WIDTH-1:0] opm_data,
  input  logic [7:0]            result_addr,
  input  logic [DATA_WIDTH-1:0] result_data,
  input  logic                  result_we
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, CLEAR} state_t;
`ifdef MONTPROD_OPMEM_CLEAR_EN
  localparam state_t FIRST = CLEAR;
  logic [7:0] clr_cnt;
`else
  localparam state_t FIRST = LAUNCH;
`endif
  logic [DATA_WIDTH-1:0] mem_a [MEM_WORDS];
  logic [DATA_WIDTH-1:0] mem_b [MEM_WORDS];
  logic [DATA_WIDTH-1:0] mem_m [MEM_WORDS];
  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];
  state_t state, state_nxt;
  logic [1:0] bank;
  logic [7:0] idx;
  logic host_wr, go;
  assign bank    = host_addr[9:8];
  assign idx     = host_addr[7:0];
  assign host_wr = host_cs && host_we && !busy;
  assign go      = start && state == IDLE;
  // Host writes to the operand banks, blocked while an operation runs
  always_ff @(posedge clk) begin
    if (host_wr && bank == 2'd0) mem_a[idx] <= host_wdata;
    if (host_wr && bank == 2'd1) mem_b[idx] <= host_wdata;
    if (host_wr && bank == 2'd2) mem_m[idx] <= host_wdata;
  end
  // Result bank: sweep clear (when built in) with montprod writes winning on a collision
  always_ff @(posedge clk) begin
`ifdef MONTPROD_OPMEM_CLEAR_EN
    if (state == CLEAR) mem_r[clr_cnt] <= '0;
`endif
    if (result_we) mem_r[result_addr] <= result_data;
  end
  // Registered read ports; reads see the word as it was before this edge's writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata <= '0;
      opa_data   <= '0;
      opb_data   <= '0;
      opm_data   <= '0;
    end else begin
      opa_data <= mem_a[opa_addr];
      opb_data <= mem_b[opb_addr];
      opm_data <= mem_m[opm_addr];
      if (host_cs && !host_we)
        host_rdata <= bank == 2'd0 ? mem_a[idx] : bank == 2'd1 ? mem_b[idx] :
                      bank == 2'd2 ? mem_m[idx] : mem_r[idx];
    end
  end
  // State register plus sticky status and latched length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      error     <= 1'b0;
      mp_length <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        done  <= length == '0;
        error <= length == '0;
        if (length != '0) mp_length <= length;
      end else if (state == WAIT_HIGH && mp_ready) done <= 1'b1;
    end
  end
`ifdef MONTPROD_OPMEM_CLEAR_EN
  // Clear sweep address, one R word per cycle while in CLEAR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clr_cnt <= '0;
    else clr_cnt <= state == CLEAR ? clr_cnt + 8'd1 : '0;
  end
`endif
  // Next state; WAIT_LOW ignores a ready left high from the previous run
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = start && length != '0 ? FIRST : IDLE;
`ifdef MONTPROD_OPMEM_CLEAR_EN
      CLEAR:     state_nxt = clr_cnt == 8'hff ? LAUNCH : CLEAR;
`endif
      LAUNCH:    state_nxt = WAIT_LOW;
      WAIT_LOW:  state_nxt = mp_ready ? WAIT_LOW : WAIT_HIGH;
      WAIT_HIGH: state_nxt = mp_ready ? IDLE : WAIT_HIGH;
      default:   state_nxt = IDLE;
    endcase
  end
  // Outputs decoded from state
  always_comb begin
    busy         = state != IDLE;
    mp_calculate = state == LAUNCH;
  end
endmodule

// File: tb/tb_montprod_opmem.sv
// tb_montprod_opmem: randomized scoreboard bench with a stand-in montprod and array reference model
module tb_montprod_opmem;
  logic tb_clk = 1'b0;
  logic reset_n = 1'b1;
  logic host_cs = 1'b0, host_we = 1'b0, start = 1'b0, mp_ready = 1'b1, result_we = 1'b0;
  logic [9:0] host_addr = '0;
  logic [31:0] host_wdata = '0, result_data = '0;
  logic [7:0] length = '0, opa_addr = '0, opb_addr = '0, opm_addr = '0, result_addr = '0;
  logic [31:0] host_rdata, opa_data, opb_data, opm_data;
  logic busy, done, error, mp_calculate;
  logic [7:0] mp_length;

  always #5 tb_clk = ~tb_clk;

  montprod_opmem dut (
    .clk(tb_clk), .reset_n(reset_n), .host_cs(host_cs), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .start(start), .length(length), .busy(busy), .done(done), .error(error),
    .mp_calculate(mp_calculate), .mp_length(mp_length), .mp_ready(mp_ready),
    .opa_addr(opa_addr), .opb_addr(opb_addr), .opm_addr(opm_addr),
    .opa_data(opa_data), .opb_data(opb_data), .opm_data(opm_data),
    .result_addr(result_addr), .result_data(result_data), .result_we(result_we)
  );

  int checks = 0, errors = 0;
  int calc_cnt = 0, exp_calc = 0;
  logic [31:0] m_a [256];
  logic [31:0] m_b [256];
  logic [31:0] m_m [256];
  logic [31:0] m_r [256];
  bit m_busy = 0, m_done = 0, m_err = 0;
  logic [7:0] exp_len = '0;
  int fm_state = 0, fm_cnt = 0, fm_len = 0;
  bit fin = 0;
  logic [31:0] host_q [$];
  logic [95:0] op_q [$];
  logic rd_flag = 1'b0, op_flag = 1'b0, op_valid = 1'b0;
  bit force_op = 0, ovr_we = 0;
  logic [7:0] force_addr = '0, ovr_addr = '0;
  logic [31:0] ovr_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [9:0] a);
    case (a[9:8])
      2'd0: return m_a[a[7:0]];
      2'd1: return m_b[a[7:0]];
      2'd2: return m_m[a[7:0]];
      default: return m_r[a[7:0]];
    endcase
  endfunction

  always @(posedge tb_clk) begin
    rd_flag <= host_cs && !host_we;
    op_flag <= op_valid;
  end

  always @(negedge tb_clk) begin
    if (mp_calculate) calc_cnt++;
    if (reset_n && rd_flag) begin
      if (host_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_q_empty actual=read required=expectation");
      end else chk("host_rdata", host_rdata, host_q.pop_front());
    end
    if (reset_n && op_flag) begin
      if (op_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL op_q_empty actual=read required=expectation");
      end else begin
        logic [95:0] e;
        e = op_q.pop_front();
        chk("opa_data", opa_data, e[95:64]);
        chk("opb_data", opb_data, e[63:32]);
        chk("opm_data", opm_data, e[31:0]);
      end
    end
  end

  // One clock: called at a falling edge, returns at the next falling edge
  task automatic step();
    fin = 0;
    result_we = 1'b0;
    if (fm_state == 0 && mp_calculate) begin
      fm_state = 1; fm_cnt = 0; fm_len = int'(mp_length); mp_ready = 1'b0;
      chk("mp_length", {24'b0, mp_length}, {24'b0, exp_len});
    end else if (fm_state == 1) begin
      if (fm_cnt < fm_len) begin
        result_we = 1'b1;
        result_addr = 8'(fm_cnt);
        result_data = (m_a[fm_cnt] + m_b[fm_cnt]) ^ m_m[fm_cnt];
        fm_cnt++;
      end else if (fm_cnt < fm_len + 3) fm_cnt++;
      else begin
        mp_ready = 1'b1; fm_state = 0; fin = 1;
      end
    end
    if (ovr_we) begin
      result_we = 1'b1; result_addr = ovr_addr; result_data = ovr_data;
    end
    opa_addr = force_op ? force_addr : 8'($urandom_range(0, 7));
    opb_addr = force_op ? force_addr : 8'($urandom_range(0, 7));
    opm_addr = force_op ? force_addr : 8'($urandom_range(0, 7));
    if (op_valid) op_q.push_back({m_a[opa_addr], m_b[opb_addr], m_m[opm_addr]});
    if (host_cs && !host_we) host_q.push_back(mrd(host_addr));
    @(posedge tb_clk);
    if (host_cs && host_we && !m_busy)
      case (host_addr[9:8])
        2'd0: m_a[host_addr[7:0]] = host_wdata;
        2'd1: m_b[host_addr[7:0]] = host_wdata;
        2'd2: m_m[host_addr[7:0]] = host_wdata;
        default: ;
      endcase
    if (result_we) m_r[result_addr] = result_data;
    if (start && !m_busy) begin
      if (length == 0) begin
        m_err = 1; m_done = 1;
      end else begin
        m_busy = 1; m_done = 0; m_err = 0; exp_len = length; exp_calc++;
`ifdef MONTPROD_OPMEM_CLEAR_EN
        for (int i = 0; i < 256; i++) m_r[i] = '0;
`endif
      end
    end
    if (fin) begin
      m_busy = 0; m_done = 1;
    end
    @(negedge tb_clk);
  endtask

  task automatic host_wr(input logic [9:0] a, input logic [31:0] d);
    host_cs = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_cs = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [9:0] a);
    host_cs = 1'b1; host_we = 1'b0; host_addr = a;
    step();
    host_cs = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1; length = len;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_busy && n < 3000) begin
      step();
      n++;
    end
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout actual=busy required=idle");
      m_busy = 0;
    end
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("error", {31'b0, error}, {31'b0, m_err});
    chk("calc_count", calc_cnt, exp_calc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge tb_clk);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    chk("rst_mp_calculate", {31'b0, mp_calculate}, 32'h0);
    chk("rst_mp_length", {24'b0, mp_length}, 32'h0);
    chk("rst_opa_data", opa_data, 32'h0);
    chk("rst_opb_data", opb_data, 32'h0);
    chk("rst_opm_data", opm_data, 32'h0);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      host_wr(10'(i), $urandom());
      host_wr(10'h100 | 10'(i), $urandom());
      host_wr(10'h200 | 10'(i), $urandom());
      ovr_we = 1; ovr_addr = 8'(i); ovr_data = $urandom();
      step();
      ovr_we = 0;
    end
    host_wr(10'h000, 32'h9);
    host_wr(10'h100, 32'h7);
    host_wr(10'h200, 32'h13);
    op_valid = 1'b1;
    step();
    host_wr(10'h005, 32'hDEADBEEF);
    host_rd(10'h005);
    force_op = 1; force_addr = 8'd5;
    step();
    force_op = 0;
    do_start(8'd1);
    wait_done();
    host_rd(10'h300);
    do_start(8'd2);
    repeat (3) step();
    host_wr(10'h000, 32'hFFFFFFFF);
    do_start(8'd3);
    wait_done();
    host_rd(10'h000);
    host_wr(10'h300, 32'hCAFEF00D);
    host_rd(10'h300);
    do_start(8'd0);
    chk("len0_error", {31'b0, error}, 32'h1);
    chk("len0_done", {31'b0, done}, 32'h1);
    repeat (3) step();
    chk("len0_calc_count", calc_cnt, exp_calc);
    host_cs = 1'b1; host_we = 1'b1; host_addr = 10'h103; host_wdata = 32'h5A5A1234;
    do_start(8'd1);
    host_cs = 1'b0; host_we = 1'b0;
    chk("restart_error", {31'b0, error}, 32'h0);
    chk("restart_done", {31'b0, done}, 32'h0);
    chk("restart_busy", {31'b0, busy}, 32'h1);
    wait_done();
    host_rd(10'h103);
    for (int k = 0; k < 300; k++) begin
      logic [1:0] b;
      b = 2'($urandom_range(0, 3));
      host_cs = 1'($urandom_range(0, 1));
      host_we = 1'($urandom_range(0, 1));
      if (host_cs && !host_we && b == 2'd3 && m_busy) b = 2'd0;
      host_addr = {b, 8'($urandom_range(0, 7))};
      host_wdata = $urandom();
      start = $urandom_range(0, 39) == 0;
      length = 8'($urandom_range(0, 8));
      step();
      host_cs = 1'b0; host_we = 1'b0; start = 1'b0;
    end
    wait_done();
    for (int i = 0; i < 8; i++) host_rd(10'h300 | 10'(i));
    ovr_we = 1; ovr_addr = 8'd200; ovr_data = 32'h1234;
    step();
    ovr_we = 0;
    do_start(8'd1);
    wait_done();
    host_rd(10'h3C8);
    do_start(8'd4);
    while (fm_state == 0 && m_busy) step();
    repeat (2) step();
    #2 reset_n = 1'b0;
    host_cs = 1'b0; start = 1'b0; result_we = 1'b0; op_valid = 1'b0;
    host_q.delete(); op_q.delete();
    m_busy = 0; m_done = 0; m_err = 0; fm_state = 0; mp_ready = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_mp_calculate", {31'b0, mp_calculate}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_host_rdata", host_rdata, 32'h0);
    @(negedge tb_clk);
    reset_n = 1'b1;
    op_valid = 1'b1;
    for (int i = 0; i < 8; i++) host_rd(10'h300 | 10'(i));
    do_start(8'd3);
    wait_done();
    for (int i = 0; i < 4; i++) host_rd(10'h300 | 10'(i));
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
